conv_window_fetch: RTL and testbench

//  Downstream consumer of the 16K-deep dual-port pixel memory. Scans a row-major IMG_W x IMG_H

---
 rtl/conv_window_fetch.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_window_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: scans a row-major image from the pixel memory and streams 3x3 stride-1 windows.
// Define ZERO_PAD_EN for same-padding (one window per pixel, centre coordinates); default is valid-only.
module conv_window_fetch #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [13:0]             rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [7:0]              win_row,
    output logic [7:0]              win_col
);

`ifdef ZERO_PAD_EN
    localparam logic signed [9:0] R_FIRST = -10'sd1;
    localparam logic signed [9:0] R_LAST  = 10'(IMG_H - 2);
    localparam logic signed [9:0] C_FIRST = -10'sd1;
    localparam logic signed [9:0] C_END   = 10'(IMG_W + 1);
    localparam logic signed [9:0] ROW_OFS = 10'sd1;
    localparam logic signed [9:0] COL_OFS = -10'sd1;
    localparam logic signed [9:0] IMG_W_S = 10'(IMG_W);
    localparam logic signed [9:0] IMG_H_S = 10'(IMG_H);
`else
    localparam logic signed [9:0] R_FIRST = 10'sd0;
    localparam logic signed [9:0] R_LAST  = 10'(IMG_H - 3);
    localparam logic signed [9:0] C_FIRST = 10'sd0;
    localparam logic signed [9:0] C_END   = 10'(IMG_W);
    localparam logic signed [9:0] ROW_OFS = 10'sd0;
    localparam logic signed [9:0] COL_OFS = -10'sd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CAPT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [1:0]              k_r;
    logic [1:0]              k_s;
    logic signed [9:0]       row_r;
    logic signed [9:0]       row_s;
    logic signed [9:0]       col_r;
    logic signed [9:0]       col_s;
    logic                    last_s;
    logic                    clear_s;
    logic                    load_win_s;
    logic signed [9:0]       tap_row_s;
    logic                    tap_in_s;
    logic [13:0]             fetch_addr_s;
    logic [DATA_WIDTH-1:0]   cap_val_s;
    logic [DATA_WIDTH-1:0]   col_new_s [3];
    logic                    tap_zero_r;
    logic                    cap_en_r;
    logic [1:0]              cap_idx_r;
    logic                    cap_zero_r;
    logic [DATA_WIDTH-1:0]   tap0_r;
    logic [DATA_WIDTH-1:0]   tap1_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and scan-position logic
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        row_s   = row_r;
        col_s   = col_r;
        last_s  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    k_s     = 2'd0;
                    row_s   = R_FIRST;
                    col_s   = C_FIRST;
                    clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (k_r == 2'd2) begin
                    state_s = ST_CAPT;
                end else begin
                    k_s = k_r + 2'd1;
                end
            end
            ST_CAPT: begin
                // a window exists once three columns of the current row are loaded
                if (col_r >= C_FIRST + 10'sd2) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_FETCH;
                    k_s     = 2'd0;
                    col_s   = col_r + 10'sd1;
                end
            end
            ST_OUT: begin
                if (win_ready) begin
                    if (col_r + 10'sd1 < C_END) begin
                        state_s = ST_FETCH;
                        k_s     = 2'd0;
                        col_s   = col_r + 10'sd1;
                    end else if (row_r + 10'sd1 <= R_LAST) begin
                        state_s = ST_FETCH;
                        k_s     = 2'd0;
                        row_s   = row_r + 10'sd1;
                        col_s   = C_FIRST;
                        clear_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        last_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: fetch address, tap range test and captured column
    always_comb begin
        tap_row_s    = row_s + $signed({8'd0, k_s});
`ifdef ZERO_PAD_EN
        tap_in_s     = (tap_row_s >= 10'sd0) && (tap_row_s < IMG_H_S) &&
                       (col_s >= 10'sd0) && (col_s < IMG_W_S);
`else
        tap_in_s     = 1'b1;
`endif
        fetch_addr_s = 14'(BASE_ADDR) + 14'($unsigned(tap_row_s)) * 14'(IMG_W) +
                       14'($unsigned(col_s));
        load_win_s   = (state_r == ST_CAPT) && (state_s == ST_OUT);
        if (cap_zero_r) begin
            cap_val_s = {DATA_WIDTH{1'b0}};
        end else begin
            cap_val_s = rd_data;
        end
        col_new_s[0] = tap0_r;
        col_new_s[1] = tap1_r;
        col_new_s[2] = cap_val_s;
    end

    // Scan counters, read address and one-cycle read-data capture pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            k_r        <= 2'd0;
            row_r      <= 10'sd0;
            col_r      <= 10'sd0;
            rd_addr    <= 14'd0;
            tap_zero_r <= 1'b0;
            cap_en_r   <= 1'b0;
            cap_idx_r  <= 2'd0;
            cap_zero_r <= 1'b0;
            tap0_r     <= {DATA_WIDTH{1'b0}};
            tap1_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            k_r   <= k_s;
            row_r <= row_s;
            col_r <= col_s;
            // suppressed (out-of-image) taps leave the address untouched
            if ((state_s == ST_FETCH) && tap_in_s) begin
                rd_addr <= fetch_addr_s;
            end
            tap_zero_r <= ~tap_in_s;
            cap_en_r   <= (state_r == ST_FETCH);
            cap_idx_r  <= k_r;
            cap_zero_r <= tap_zero_r;
            if (cap_en_r && (cap_idx_r == 2'd0)) begin
                tap0_r <= cap_val_s;
            end
            if (cap_en_r && (cap_idx_r == 2'd1)) begin
                tap1_r <= cap_val_s;
            end
        end
    end

    // Window shift register and stream/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            win_data  <= {(9*DATA_WIDTH){1'b0}};
            win_valid <= 1'b0;
            win_row   <= 8'd0;
            win_col   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (clear_s) begin
                win_data <= {(9*DATA_WIDTH){1'b0}};
            end else if (cap_en_r && (cap_idx_r == 2'd2)) begin
                for (int i = 0; i < 3; i++) begin
                    win_data[(3*i)*DATA_WIDTH   +: DATA_WIDTH] <= win_data[(3*i+1)*DATA_WIDTH +: DATA_WIDTH];
                    win_data[(3*i+1)*DATA_WIDTH +: DATA_WIDTH] <= win_data[(3*i+2)*DATA_WIDTH +: DATA_WIDTH];
                    win_data[(3*i+2)*DATA_WIDTH +: DATA_WIDTH] <= col_new_s[i];
                end
            end
            if (load_win_s) begin
                win_row <= 8'(row_r + ROW_OFS);
                win_col <= 8'(col_r + COL_OFS);
            end
            win_valid <= (state_s == ST_OUT);
            busy      <= (state_s != ST_IDLE);
            done      <= last_s;
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed, table-driven bench for conv_window_fetch on a 4x4 image with mem[a]=a.
`timescale 1ns/1ps
module tb_conv_window_fetch;
    localparam int DW = 24;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int WB = 9 * DW;
`ifdef ZERO_PAD_EN
    localparam int WPR = IW;
    localparam int NWIN = IW * IH;
`else
    localparam int WPR = IW - 2;
    localparam int NWIN = (IW - 2) * (IH - 2);
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [13:0]   rd_addr;
    logic [DW-1:0] rd_data;
    logic          win_valid;
    logic          win_ready;
    logic [WB-1:0] win_data;
    logic [7:0]    win_row;
    logic [7:0]    win_col;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct {
        int            hold;     // cycles to keep win_ready low on this window (stall passes)
        bit            restart;  // pulse start while this window is presented (stall passes)
        int            gap;      // cycles from previous start/acceptance to win_valid
        int            row;
        int            col;
        logic [WB-1:0] taps;
    } vec_t;

    vec_t vecs [NWIN];

    conv_window_fetch #(
        .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .win_valid(win_valid),
        .win_ready(win_ready), .win_data(win_data), .win_row(win_row), .win_col(win_col)
    );

    always #5 clk = ~clk;

    // memory read port: mem[a] = a, one-cycle latency
    always @(posedge clk) begin
        rd_data <= DW'(rd_addr);
        cyc     <= cyc + 1;
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WB-1:0] pack9(input int t0, input int t1, input int t2,
                                            input int t3, input int t4, input int t5,
                                            input int t6, input int t7, input int t8);
        logic [WB-1:0] w;
        w = {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
        return w;
    endfunction

    // r,c: window top-left (valid mode) or centre (padded mode)
    function automatic logic [WB-1:0] model_win(input int r, input int c);
        logic [WB-1:0] w;
        int pr;
        int pc;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
`ifdef ZERO_PAD_EN
                pr = r - 1 + i;
                pc = c - 1 + j;
`else
                pr = r + i;
                pc = c + j;
`endif
                if (pr >= 0 && pr < IH && pc >= 0 && pc < IW)
                    w[(3*i+j)*DW +: DW] = DW'(pr * IW + pc);
            end
        end
        return w;
    endfunction

    task automatic run_pass(input bit use_stalls);
        int            ref_cyc;
        int            wait_n;
        int            dc0;
        int            extra;
        bit            stable;
        logic [WB-1:0] d0;
        logic [13:0]   a0;
        dc0 = done_cnt;
        @(negedge clk);
        start   = 1'b1;
        ref_cyc = cyc;
        for (int n = 0; n < NWIN; n++) begin
            win_ready = !(use_stalls && vecs[n].hold > 0);
            wait_n = 0;
            do begin
                @(negedge clk);
                start = 1'b0;
                wait_n++;
            end while (!win_valid && wait_n < 40);
            if (!win_valid) begin
                chk($sformatf("win_valid timeout w%0d", n), 64'(win_valid), 64'd1);
                return;
            end
            chk($sformatf("gap w%0d", n), 64'(cyc - ref_cyc), 64'(vecs[n].gap));
            chk($sformatf("win_row w%0d", n), 64'(win_row), 64'(vecs[n].row));
            chk($sformatf("win_col w%0d", n), 64'(win_col), 64'(vecs[n].col));
            chk_win($sformatf("win_data w%0d", n), win_data, vecs[n].taps);
            chk($sformatf("busy w%0d", n), 64'(busy), 64'd1);
            if (use_stalls && vecs[n].restart) start = 1'b1;
            if (use_stalls && vecs[n].hold > 0) begin
                d0 = win_data;
                a0 = rd_addr;
                for (int h = 1; h < vecs[n].hold; h++) begin
                    @(negedge clk);
                    start  = 1'b0;
                    stable = win_valid && (win_data === d0) && (rd_addr === a0) &&
                             (win_row == 8'(vecs[n].row)) && (win_col == 8'(vecs[n].col));
                    chk($sformatf("stall stable w%0d h%0d", n, h), 64'(stable), 64'd1);
                end
                win_ready = 1'b1;
            end
            ref_cyc = cyc;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done pulse", 64'(done), 64'd1);
        chk("busy after done", 64'(busy), 64'd0);
        chk("valid after done", 64'(win_valid), 64'd0);
        @(negedge clk);
        chk("done single cycle", 64'(done), 64'd0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (win_valid) extra++;
        end
        chk("extra windows", 64'(extra), 64'd0);
        chk("done count", 64'(done_cnt - dc0), 64'd1);
    endtask

    initial begin
        int dc;
        reset     = 1'b1;
        start     = 1'b0;
        win_ready = 1'b0;

        for (int n = 0; n < NWIN; n++) begin
            vecs[n].hold    = 0;
            vecs[n].restart = 1'b0;
            vecs[n].row     = n / WPR;
            vecs[n].col     = n % WPR;
            vecs[n].gap     = (n % WPR == 0) ? 13 : 5;
            vecs[n].taps    = model_win(n / WPR, n % WPR);
        end
        vecs[0].hold    = 10;
        vecs[1].restart = 1'b1;
`ifdef ZERO_PAD_EN
        vecs[0].taps        = pack9(0, 0, 0, 0, 0, 1, 0, 4, 5);
        vecs[NWIN-1].taps   = pack9(10, 11, 0, 14, 15, 0, 0, 0, 0);
`else
        vecs[0].taps        = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        vecs[NWIN-1].taps   = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);
`endif

        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset win_valid", 64'(win_valid), 64'd0);
        chk("reset rd_addr", 64'(rd_addr), 64'd0);
        chk("reset win_row", 64'(win_row), 64'd0);
        chk("reset win_col", 64'(win_col), 64'd0);
        chk_win("reset win_data", win_data, '0);
        reset = 1'b0;
        @(negedge clk);

        run_pass(1'b0);
        run_pass(1'b1);

        // reset in cycle 8 of a pass
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy before mid-pass reset", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort win_valid", 64'(win_valid), 64'd0);
        chk("abort rd_addr", 64'(rd_addr), 64'd0);
        chk("abort win_row", 64'(win_row), 64'd0);
        chk("abort win_col", 64'(win_col), 64'd0);
        chk_win("abort win_data", win_data, '0);
        repeat (20) @(negedge clk);
        chk("abort stays idle", 64'(busy | win_valid), 64'd0);
        chk("abort no done", 64'(done_cnt - dc), 64'd0);

        run_pass(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
